// File: rtl/subtractor_16_bit_serial_pkg.sv
// Shared definitions for the bit-serial 16-bit subtractor: default width and FSM encodings.
package subtractor_16_bit_serial_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/subtractor_16_bit_serial_full_subtractor.sv
// One-bit combinational full subtractor: D = A - B - Bin with borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/subtractor_16_bit_serial.sv
// Bit-serial subtractor: one full_subtractor reused LSB-first over WIDTH cycles,
// results (D, Bout, Bout_1, V) loaded together on the final bit.
module subtractor_16_bit_serial
  import subtractor_16_bit_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Bout_1,
  output logic             V
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d, b1_q, b1_d;
  logic             bout_q, bout_d, bout1_q, bout1_d, v_q, v_d;
  logic             fs_d, fs_bout;

  full_subtractor u_fs (
    .A   (a_q[0]),
    .B   (b_q[0]),
    .Bin (brw_q),
    .D   (fs_d),
    .Bout(fs_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    b1_d    = b1_q;
    dout_d  = dout_q;
    bout_d  = bout_q;
    bout1_d = bout1_q;
    v_d     = v_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          brw_d   = Bin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        r_d   = {fs_d, r_q[WIDTH-1:1]};
        brw_d = fs_bout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 2)) b1_d = fs_bout;
        // Final bit: the last difference bit is merged straight into D.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          dout_d  = {fs_d, r_q[WIDTH-1:1]};
          bout_d  = fs_bout;
          bout1_d = b1_q;
          v_d     = fs_bout ^ b1_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      b1_q    <= 1'b0;
      dout_q  <= '0;
      bout_q  <= 1'b0;
      bout1_q <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      b1_q    <= b1_d;
      dout_q  <= dout_d;
      bout_q  <= bout_d;
      bout1_q <= bout1_d;
      v_q     <= v_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign D      = dout_q;
  assign Bout   = bout_q;
  assign Bout_1 = bout1_q;
  assign V      = v_q;

endmodule

// File: tb/tb_subtractor_16_bit_serial.sv
// Directed table-driven bench for subtractor_16_bit_serial plus multi-cycle corner sequences.
module tb_subtractor_16_bit_serial;

  logic        clk = 1'b0;
  logic        rst, start, Bin;
  logic [15:0] A, B;
  logic        busy, done, Bout, Bout_1, V;
  logic [15:0] D;

  int n_chk  = 0;
  int n_pass = 0;

  subtractor_16_bit_serial #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .D(D), .Bout(Bout), .Bout_1(Bout_1), .V(V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        bin;
    logic [15:0] d;
    logic        bout, bout1, v;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive a start on the next edge (E0); returns #1 after E0.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bin);
    start = 1'b1; A = a; B = b; Bin = bin;
    @(posedge clk); #1;
    start = 1'b0; A = 16'hxxxx; B = 16'hxxxx; Bin = 1'bx;
  endtask

  // Count edges after E0 until done; flags any busy/done misbehaviour before it.
  task automatic wait_done(output int lat, output int bad);
    lat = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (!busy) bad++;
    end
    if (!done) lat = -1;
  endtask

  task automatic check_out(input string tag, input vec_t v);
    chk({tag, ".D"},      {16'h0, D},      {16'h0, v.d});
    chk({tag, ".Bout"},   {31'h0, Bout},   {31'h0, v.bout});
    chk({tag, ".Bout_1"}, {31'h0, Bout_1}, {31'h0, v.bout1});
    chk({tag, ".V"},      {31'h0, V},      {31'h0, v.v});
  endtask

  initial begin
    int lat, bad, seen;
    vec_t r52;

    vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{16'h0010, 16'h0010, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1, 1'b1};
    r52     = vecs[0];

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", {31'h0, busy}, 32'h0);
    chk("rst.done", {31'h0, done}, 32'h0);
    check_out("rst", '{16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].bin);
      chk($sformatf("v%0d.busy_after_E0", i), {31'h0, busy}, 32'h1);
      wait_done(lat, bad);
      chk($sformatf("v%0d.latency", i), lat, 32'd16);
      chk($sformatf("v%0d.busy_gaps", i), bad, 32'd0);
      chk($sformatf("v%0d.busy_in_done", i), {31'h0, busy}, 32'h0);
      check_out($sformatf("v%0d", i), vecs[i]);
      @(posedge clk); #1;
      chk($sformatf("v%0d.done_pulse", i), {31'h0, done}, 32'h0);
      check_out($sformatf("v%0d.hold", i), vecs[i]);
    end

    // start during RUN must not disturb the operation in flight
    issue(16'h0005, 16'h0003, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; A = 16'h1234; B = 16'h0001; Bin = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bad);
    chk("ign.latency", lat, 32'd9);
    check_out("ign", r52);

    // back-to-back: start held in the DONE cycle
    start = 1'b1; A = 16'h0000; B = 16'h0001; Bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b.busy", {31'h0, busy}, 32'h1);
    chk("b2b.done", {31'h0, done}, 32'h0);
    wait_done(lat, bad);
    chk("b2b.latency", lat, 32'd16);
    check_out("b2b", vecs[1]);
    @(posedge clk); #1;

    // reset at E8 aborts with no done pulse and clears outputs
    issue(16'h8000, 16'h0001, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.busy", {31'h0, busy}, 32'h0);
    chk("abort.done", {31'h0, done}, 32'h0);
    check_out("abort", '{16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0});
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("abort.quiet", seen, 32'd0);

    // rst wins over start on the same edge
    rst = 1'b1; start = 1'b1; A = 16'h0005; B = 16'h0003; Bin = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_prio.busy", {31'h0, busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/subtractor_16_bit_serial.md
SUBTRACTOR_16_BIT_SERIAL -- requirements
Module: subtractor_16_bit_serial

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; fixed at 16 for this release.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 A  input  16  minuend; captured on the accepting edge.
REQ-006 B  input  16  subtrahend; captured on the accepting edge.
REQ-007 Bin  input  1  borrow-in; captured on the accepting edge.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse; result outputs newly valid.
REQ-010 D  output  16  difference A - B - Bin (mod 2^16).
REQ-011 Bout  output  1  borrow out of bit 15.
REQ-012 Bout_1  output  1  borrow out of bit 14.
REQ-013 V  output  1  signed overflow; equals Bout XOR Bout_1.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 Start acceptance SHALL occur at edge E0 when start=1 in IDLE or DONE:
- Capture A, B and Bin.
- Clear the bit counter.
- Enter RUN.
REQ-016 Edges E1..E16 SHALL process one bit each, LSB first, with the borrow held in a 1-bit register between bits:
- Bit i difference d = a XOR b XOR bin.
- Borrow-out = (~a & b) | (~(a XOR b) & bin).
REQ-017 The borrow-out of bit 14 SHALL be latched for Bout_1.
REQ-018 At E16 the FSM SHALL enter DONE and load D, Bout, Bout_1 and V together.
REQ-019 busy SHALL be 1 exactly in RUN, from after E0 until after E16.
REQ-020 done SHALL be 1 exactly in DONE, for one cycle, 16 cycles after E0.
REQ-021 start while busy=1 SHALL be ignored, with no effect on operands or counter.
REQ-022 From DONE, the FSM SHALL go to RUN if start=1 (back-to-back) and otherwise to IDLE.
REQ-023 D, Bout, Bout_1 and V SHALL hold their last values until the next E16 or reset.
REQ-024 Operand inputs SHALL be don't-care outside the accepting edge.
REQ-025 Bout SHALL be 1 iff unsigned A < B + Bin.

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL:
- Force IDLE.
- Force busy=0, done=0, D=0, Bout=0, Bout_1=0 and V=0.
- Clear the counter, operand registers and borrow register.
REQ-027 Reset during RUN SHALL abort the operation with no done pulse, and the outputs SHALL NOT be updated with a partial result.
REQ-028 rst SHALL take priority over start on the same edge.

Structure
REQ-029 A shared definitions include file SHALL hold the WIDTH default and the IDLE/RUN/DONE state encodings.
REQ-030 A one-bit combinational sub-module full_subtractor (ports A, B, Bin, D, Bout) SHALL be instantiated once and reused every cycle.
REQ-031 Internal storage SHALL be:
- Two 16-bit right-shift operand registers.
- A 16-bit result shift register.
- A 4-bit counter.
- Borrow and Bout_1 latches.

Verification
REQ-032 A=0x0005, B=0x0003, Bin=0 -> D=0x0002, Bout=0, Bout_1=0, V=0; done exactly 16 cycles after E0.
REQ-033 A=0x0000, B=0x0001, Bin=0 -> D=0xFFFF, Bout=1, Bout_1=1, V=0.
REQ-034 A=0x8000, B=0x0001, Bin=0 -> D=0x7FFF, Bout=0, Bout_1=1, V=1.
REQ-035 A=0x0010, B=0x0010, Bin=1 -> D=0xFFFF, Bout=1, V=0.
REQ-036 Second start with A=0x1234 during RUN -> ignored; first result D=0x0002 still delivered.
- start held high in the DONE cycle -> new operation begins with no IDLE gap.
REQ-037 rst asserted at E8 of an operation -> busy=0 next cycle, no done pulse, all outputs 0.
